// File: rtl/div_unit_pkg.sv
// Shared encodings and widths for the multi-cycle divider.
package div_unit_pkg;

  localparam int unsigned RegBusW       = 32;
  localparam int unsigned DoubleRegBusW = 64;
  localparam int unsigned DivCntW       = 6;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate, used for operand abs and result sign fixup.
//   neg_i  : 1 = output -data_i, 0 = pass data_i through
//   data_i : input word
//   data_c : combinational result
module div_abs_neg
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = RegBusW
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_c
);

  assign data_c = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU beside the EX stage.
//   clk, rst     : clock, synchronous active-high reset
//   signed_div_i : 1 = DIV, 0 = DIVU
//   opdata1_i/2_i: dividend / divisor, captured only when leaving FREE
//   start_i      : request, held by EX until ready_o
//   annul_i      : abort (EX flush); ignored once the result is ready
//   result_o     : {remainder, quotient}, zero whenever ready_o is low
//   ready_o      : result valid
//   stallreq_o   : combinational stall request to the pipeline
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = RegBusW,
  parameter int unsigned CNT_W = DivCntW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stallreq_o
);

  localparam int unsigned ResW = 2 * WIDTH;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [ResW-1:0]  result_q, result_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
  logic [WIDTH:0]   shifted, trial;

  // Magnitudes of the incoming operands (only differ from raw in signed mode).
  div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
    .neg_i (signed_div_i & opdata1_i[WIDTH-1]),
    .data_i(opdata1_i),
    .data_c(abs_a)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .neg_i (signed_div_i & opdata2_i[WIDTH-1]),
    .data_i(opdata2_i),
    .data_c(abs_b)
  );

  // Sign fixup: quotient follows sign(a)^sign(b), remainder follows sign(a).
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .neg_i (sign_a_q ^ sign_b_q),
    .data_i(quo_q),
    .data_c(quo_fix)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i (sign_a_q),
    .data_i(rem_q),
    .data_c(rem_fix)
  );

  // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
  // The shifted value can reach WIDTH+1 bits when the divisor has its MSB set.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d  = DivOn;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = abs_a;
            dvs_d    = abs_b;
            sign_a_d = signed_div_i & opdata1_i[WIDTH-1];
            sign_b_d = signed_div_i & opdata2_i[WIDTH-1];
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  // Drops as soon as the result is visible so EX can advance that same cycle.
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes reference results, a monitor pops on ready_o.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic ready_prev = 1'b0;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stallreq_o  (stallreq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division; SV truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop on each rising ready_o; result must be zero whenever not ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (ready_o && !ready_prev) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready: ready_o rose at cycle %0d with nothing pending", cyc);
        end else begin
          sb_e = sb_q.pop_front();
          check("result", result_o, sb_e.res);
          check("latency", 64'(cyc), 64'(sb_e.cyc));
        end
      end
      if (!ready_o) check("idle_result_zero", result_o, 64'd0);
    end
    ready_prev <= ready_o;
  end

  // Issue one op with start held until ready, scrambling operands after capture.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    int   t0, lat, stall_cnt;
    logic got;
    exp_t e;
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    t0         = cyc;
    lat        = (b == 32'd0) ? 2 : 34;
    e.res      = model(s, a, b);
    e.cyc      = t0 + lat;
    sb_q.push_back(e);
    stall_cnt  = 0;
    got        = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ready_o) got = 1'b1;
      else begin
        if (stallreq_o) stall_cnt++;
        if (cyc > t0) begin
          op1        = $urandom;
          op2        = $urandom;
          signed_div = 1'($urandom_range(0, 1));
        end
      end
    end
    check("ready_seen", 64'(got), 64'd1);
    check("stall_cycles", 64'(stall_cnt), 64'(lat));
    check("stall_at_ready", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("free_ready_low", 64'(ready_o), 64'd0);
    check("free_result_zero", result_o, 64'd0);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    check("reset_state", 64'(dut.state_q), 64'(DivFree));
    rst = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, 32'd100, 32'd7);
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 32'd5, 32'd0);
    issue(1'b1, 32'd0, 32'd12345);
    issue(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);

    // Annul at iteration 10 with start still high.
    signed_div = 1'b0; op1 = $urandom; op2 = $urandom_range(1, 1000); start = 1'b1;
    repeat (11) @(posedge clk); #1;
    annul = 1'b1;
    @(negedge clk);
    check("stall_annul", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk); #1;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_state", 64'(dut.state_q), 64'(DivFree));
    issue(1'b0, 32'd9, 32'd3);

    // Reset at iteration 20.
    signed_div = 1'b1; op1 = $urandom; op2 = $urandom_range(1, 99999); start = 1'b1;
    repeat (21) @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_stall", 64'(stallreq_o), 64'd0);
    check("rst_mid_state", 64'(dut.state_q), 64'(DivFree));
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 32'd1, 32'd1);

    // Randomized mix.
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      issue(s, a, b);
    end

    repeat (3) @(posedge clk); #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit restoring divider for DIV/DIVU.
- Sits beside the EX stage and produces the 64-bit {HI,LO} result that EX forwards as ex_hi/ex_lo with ex_whilo=1 into the EX/MEM register.
- HI carries the remainder; LO carries the quotient.
- Requests a pipeline stall while busy and supports annulment when EX is flushed.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk         input   1        clock
- rst         input   1        reset (already decided)
- signed_div_i input  1        1 = signed DIV, 0 = DIVU
- opdata1_i   input   WIDTH    dividend
- opdata2_i   input   WIDTH    divisor
- start_i     input   1        request; held high by EX until ready_o is seen
- annul_i     input   1        abort the current operation (flush)
- result_o    output  2*WIDTH  {remainder, quotient}
- ready_o     output  1        result_o valid
- stallreq_o  output  1        combinational stall request: start_i & ~ready_o & ~annul_i

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk. On rst, state=FREE, cnt=0, result_o=0, ready_o=0, and internal dividend/divisor/partial-remainder registers=0. Reset mid-operation aborts immediately; nothing leaks out.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. Latch the operands; in signed mode latch the absolute values, plus the sign of the dividend and the sign of the divisor. Set cnt=0.
  - Otherwise stay FREE; ready_o=0, result_o=0.
- BYZERO: next cycle -> END with result_o=0 and ready_o=1. If annul_i=1, go to FREE instead.
- ON, one restoring step per cycle while cnt<WIDTH:
  - Shift {rem,quo} left by 1.
  - Compute trial = rem - divisor (WIDTH+1-bit subtract).
  - If no borrow: rem=trial and set the quotient LSB to 1.
  - Increment cnt.
- ON, at cnt==WIDTH: apply the sign fixup, load result_o, set ready_o=1, go to END.
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
- ON with annul_i=1: go to FREE in the next cycle; ready_o stays 0 and result_o stays 0.
- END: hold result_o and ready_o=1 while start_i=1. When start_i=0, go to FREE and clear ready_o and result_o to 0 in the next cycle. annul_i is ignored in END.
- Latency, with start sampled in FREE at cycle T:
  - divisor!=0: ready_o is first high in cycle T+WIDTH+2 (T+34 at default). This is WIDTH iteration cycles plus one fixup cycle in ON.
  - divisor==0: ready_o is first high in cycle T+2.
- Operand capture: operands are captured only on the FREE->ON/BYZERO transition. Later operand changes are ignored until the divider is back in FREE.
- Arithmetic: all wrap at WIDTH bits. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (no trap). Dividend 0 gives quotient 0 and remainder 0.
- Back-to-back: a new start_i may be accepted in the first FREE cycle after END. There is no FREE bypass.
- stallreq_o:
  - High from the first start_i cycle until ready_o is high.
  - Low in any cycle where annul_i=1.
  - Low in the cycle where ready_o is already 1, which lets EX advance.

Decomposition:
- Shared package / defines.v gets:
  - State encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - RegBus / DoubleRegBus widths.
- One optional sub-module, div_abs_neg (conditional two's-complement negate), instantiated for operand abs and result fixup. Everything else stays flat.

Test Plan:
- DIVU 100/7, start held -> ready_o high in cycle T+34; result_o={32'h00000002, 32'h0000000E}; stallreq_o high for cycles T..T+33 and low at T+34.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}. Repeat with 7/-2 -> {32'h00000001, 32'hFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o={32'h00000000, 32'h80000000}.
- Divide by zero (5/0) -> ready_o=1 at T+2 with result_o=0. Drop start_i -> FREE next cycle with ready_o=0.
- Annul at iteration 10 with start_i still high, then deassert start_i -> ready_o never rises and the state is FREE. A new DIVU 9/3 afterwards gives {0, 3} with the full latency.
- Assert rst at iteration 20 -> next cycle all outputs 0 and state FREE. After release, start 1/1 gives {0, 1}.
